// File: rtl/change_return_timer_if.sv
// change_return_timer bus: activity/balance inputs and coin-return outputs.
// master = coin/item datapath side, slave = change_return_timer.
interface change_return_timer_if #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int VALUE_BITS = 16,
  parameter int TIMER_BITS = 32
);
  logic [NUM_COINS-1:0]            i_input_coin;
  logic [NUM_ITEMS-1:0]            i_output_item;
  logic                            i_trigger_return;
  logic [TOTAL_BITS-1:0]           i_current_total;
  logic [NUM_COINS*VALUE_BITS-1:0] i_coin_value;
  logic [NUM_COINS-1:0]            o_return_coin;
  logic                            o_return_busy;
  logic                            o_return_done;
  logic [TOTAL_BITS-1:0]           o_residual;
  logic [TIMER_BITS-1:0]           o_wait_time;
  logic                            o_warn;

  modport master (
    output i_input_coin, i_output_item, i_trigger_return,
    output i_current_total, i_coin_value,
    input  o_return_coin, o_return_busy, o_return_done,
    input  o_residual, o_wait_time, o_warn
  );

  modport slave (
    input  i_input_coin, i_output_item, i_trigger_return,
    input  i_current_total, i_coin_value,
    output o_return_coin, o_return_busy, o_return_done,
    output o_residual, o_wait_time, o_warn
  );
endinterface

// File: rtl/change_return_timer.sv
// Inactivity timer with greedy one-coin-per-cycle change return.
// Optional timeout warning output enabled by CHANGE_RETURN_WARN_EN.
module change_return_timer #(
  parameter int NUM_COINS  = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int TOTAL_BITS = 31,
  parameter int VALUE_BITS = 16,
  parameter int TIMER_BITS = 32,
  parameter int WAIT_TIME  = 10,
  parameter int WARN_TIME  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  change_return_timer_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_RETURN
  } state_t;

  localparam logic [TIMER_BITS-1:0] LP_WAIT =
    TIMER_BITS'(WAIT_TIME);

  // Reject configurations the timer/greedy logic cannot honour.
  if (WAIT_TIME < 1 || WARN_TIME >= WAIT_TIME ||
      VALUE_BITS > TOTAL_BITS ||
      $bits(bus.i_output_item) != NUM_ITEMS ||
      $bits(bus.i_input_coin) != NUM_COINS) begin : g_bad_cfg
    $error("change_return_timer: bad parameters");
  end

  state_t                r_state;
  state_t                w_state;
  logic [TIMER_BITS-1:0] r_wait_time;
  logic [TIMER_BITS-1:0] w_wait_time;
  logic [TOTAL_BITS-1:0] r_remaining;
  logic [TOTAL_BITS-1:0] w_remaining;
  logic [NUM_COINS-1:0]  r_return_coin;
  logic [NUM_COINS-1:0]  w_return_coin;
  logic                  r_return_busy;
  logic                  w_return_busy;
  logic                  r_return_done;
  logic                  w_return_done;
  logic [TOTAL_BITS-1:0] r_residual;
  logic [TOTAL_BITS-1:0] w_residual;

  logic                  w_activity;
  logic                  w_total_nz;
  logic                  w_found;
  logic [NUM_COINS-1:0]  w_pick;
  logic [TOTAL_BITS-1:0] w_pick_val;

  assign w_activity = (|bus.i_input_coin) ||
                      (|bus.i_output_item);
  assign w_total_nz = |bus.i_current_total;

  // Greedy pick: highest enabled denomination that fits.
  always_comb begin
    logic [TOTAL_BITS-1:0] v;
    w_found    = 1'b0;
    w_pick     = '0;
    w_pick_val = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      v = '0;
      v[VALUE_BITS-1:0] =
        bus.i_coin_value[k*VALUE_BITS +: VALUE_BITS];
      if (v != '0 && v <= r_remaining) begin
        w_found    = 1'b1;
        w_pick     = '0;
        w_pick[k]  = 1'b1;
        w_pick_val = v;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state       = r_state;
    w_wait_time   = r_wait_time;
    w_remaining   = r_remaining;
    w_return_coin = '0;
    w_return_busy = r_return_busy;
    w_return_done = 1'b0;
    w_residual    = r_residual;
    unique case (1'b1)
      r_state == S_IDLE: begin
        if (w_activity) begin
          w_wait_time = LP_WAIT;
        end else if (bus.i_trigger_return ||
                     (r_wait_time == '0 && w_total_nz)) begin
          w_state       = S_RETURN;
          w_remaining   = bus.i_current_total;
          w_return_busy = 1'b1;
        end else if (r_wait_time != '0) begin
          w_wait_time = r_wait_time - 1'b1;
        end
      end
      r_state == S_RETURN: begin
        if (w_found) begin
          w_return_coin = w_pick;
          w_remaining   = r_remaining - w_pick_val;
        end else begin
          w_return_done = 1'b1;
          w_residual    = r_remaining;
          w_return_busy = 1'b0;
          w_wait_time   = LP_WAIT;
          w_state       = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_wait_time   <= LP_WAIT;
      r_remaining   <= '0;
      r_return_coin <= '0;
      r_return_busy <= 1'b0;
      r_return_done <= 1'b0;
      r_residual    <= '0;
    end else begin
      r_state       <= w_state;
      r_wait_time   <= w_wait_time;
      r_remaining   <= w_remaining;
      r_return_coin <= w_return_coin;
      r_return_busy <= w_return_busy;
      r_return_done <= w_return_done;
      r_residual    <= w_residual;
    end
  end

`ifdef CHANGE_RETURN_WARN_EN
  localparam logic [TIMER_BITS-1:0] LP_WARN =
    TIMER_BITS'(WARN_TIME);

  logic r_warn;
  logic w_warn;

  // Warn only while staying idle with money at stake.
  always_comb begin
    w_warn = (r_state == S_IDLE) && (w_state == S_IDLE) &&
             (w_wait_time != '0) &&
             (w_wait_time <= LP_WARN) && w_total_nz;
  end

  // Warning register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= w_warn;
    end
  end

  assign bus.o_warn = r_warn;
`else
  assign bus.o_warn = 1'b0;
`endif

  assign bus.o_return_coin = r_return_coin;
  assign bus.o_return_busy = r_return_busy;
  assign bus.o_return_done = r_return_done;
  assign bus.o_residual    = r_residual;
  assign bus.o_wait_time   = r_wait_time;

endmodule

// File: tb/tb_change_return_timer.sv
// Directed bench for change_return_timer (default parameters).
// Expected o_warn depends on CHANGE_RETURN_WARN_EN.
module tb_change_return_timer;

`ifdef CHANGE_RETURN_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  change_return_timer_if u_if ();

  change_return_timer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  coin;
    logic [3:0]  item;
    logic        trig;
    logic [30:0] total;
    logic [2:0]  ecoin;
    logic        ebusy;
    logic        edone;
    logic [30:0] eres;
    logic [31:0] ewait;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [2:0] ecoin,
                         input logic ebusy,
                         input logic edone,
                         input logic [30:0] eres,
                         input logic [31:0] ewait,
                         input logic ewarn);
    chk({tag, ".coin"}, 64'(u_if.o_return_coin), 64'(ecoin));
    chk({tag, ".busy"}, 64'(u_if.o_return_busy), 64'(ebusy));
    chk({tag, ".done"}, 64'(u_if.o_return_done), 64'(edone));
    chk({tag, ".res"},  64'(u_if.o_residual),    64'(eres));
    chk({tag, ".wait"}, 64'(u_if.o_wait_time),   64'(ewait));
    chk({tag, ".warn"}, 64'(u_if.o_warn),        64'(ewarn));
  endtask

  function automatic logic exp_warn(input int w,
                                    input int tot);
    return WARN_ON && w >= 1 && w <= 3 && tot != 0;
  endfunction

  initial begin
    int w;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{0, 0, 1, 160, 3'b000, 1, 0, 0, 10};
    vecs[1]  = '{0, 0, 0, 160, 3'b100, 1, 0, 0, 10};
    vecs[2]  = '{0, 0, 0, 160, 3'b010, 1, 0, 0, 10};
    vecs[3]  = '{0, 0, 0, 160, 3'b001, 1, 0, 0, 10};
    vecs[4]  = '{0, 0, 0, 160, 3'b000, 0, 1, 0, 10};
    vecs[5]  = '{0, 0, 0, 160, 3'b000, 0, 0, 0, 9};
    vecs[6]  = '{0, 0, 1, 75,  3'b000, 1, 0, 0, 9};
    vecs[7]  = '{0, 0, 0, 75,  3'b010, 1, 0, 0, 9};
    vecs[8]  = '{0, 0, 0, 75,  3'b001, 1, 0, 0, 9};
    vecs[9]  = '{0, 0, 0, 75,  3'b001, 1, 0, 0, 9};
    vecs[10] = '{0, 0, 0, 75,  3'b000, 0, 1, 5, 10};
    vecs[11] = '{0, 0, 0, 0,   3'b000, 0, 0, 5, 9};
    vecs[12] = '{0, 0, 1, 0,   3'b000, 1, 0, 5, 9};
    vecs[13] = '{0, 0, 0, 0,   3'b000, 0, 1, 0, 10};
    vecs[14] = '{1, 0, 1, 30,  3'b000, 0, 0, 0, 10};
    vecs[15] = '{0, 2, 0, 30,  3'b000, 0, 0, 0, 10};
    vecs[16] = '{0, 0, 0, 30,  3'b000, 0, 0, 0, 9};
    vecs[17] = '{0, 0, 1, 10,  3'b000, 1, 0, 0, 9};
    vecs[18] = '{2, 0, 1, 10,  3'b001, 1, 0, 0, 9};
    vecs[19] = '{0, 0, 0, 10,  3'b000, 0, 1, 0, 10};

    reset_n                = 1'b0;
    u_if.i_input_coin      = '0;
    u_if.i_output_item     = '0;
    u_if.i_trigger_return  = 1'b0;
    u_if.i_current_total   = '0;
    u_if.i_coin_value      = {16'd100, 16'd50, 16'd10};
    tick();
    tick();
    chk_all("reset", 3'b000, 0, 0, 0, 10, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      u_if.i_input_coin     = vecs[i].coin;
      u_if.i_output_item    = vecs[i].item;
      u_if.i_trigger_return = vecs[i].trig;
      u_if.i_current_total  = vecs[i].total;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ecoin,
              vecs[i].ebusy, vecs[i].edone, vecs[i].eres,
              vecs[i].ewait, 1'b0);
    end

    u_if.i_input_coin     = '0;
    u_if.i_output_item    = '0;
    u_if.i_trigger_return = 1'b0;
    u_if.i_current_total  = 31'd250;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_all($sformatf("tmo%0d", i), 3'b000, 0, 0, 0,
              32'(10 - i), exp_warn(10 - i, 250));
    end
    tick();
    chk_all("tmo_enter", 3'b000, 1, 0, 0, 0, 0);
    tick();
    chk_all("tmo_c1", 3'b100, 1, 0, 0, 0, 0);
    tick();
    chk_all("tmo_c2", 3'b100, 1, 0, 0, 0, 0);
    tick();
    chk_all("tmo_c3", 3'b010, 1, 0, 0, 0, 0);
    tick();
    chk_all("tmo_done", 3'b000, 0, 1, 0, 10, 0);

    u_if.i_current_total = 31'd30;
    w = 10;
    for (int i = 0; i < 40; i++) begin
      u_if.i_input_coin = (i % 9 == 8) ? 3'b001 : 3'b000;
      tick();
      w = (i % 9 == 8) ? 10 : w - 1;
      chk($sformatf("act%0d.wait", i),
          64'(u_if.o_wait_time), 64'(w));
      chk($sformatf("act%0d.busy", i),
          64'(u_if.o_return_busy), 64'd0);
      chk($sformatf("act%0d.warn", i),
          64'(u_if.o_warn), 64'(exp_warn(w, 30)));
    end
    u_if.i_input_coin = '0;

    u_if.i_current_total  = 31'd250;
    u_if.i_trigger_return = 1'b1;
    tick();
    chk("rst_seq.busy", 64'(u_if.o_return_busy), 64'd1);
    u_if.i_trigger_return = 1'b0;
    tick();
    chk("rst_seq.coin", 64'(u_if.o_return_coin), 64'd4);
    reset_n = 1'b0;
    tick();
    chk_all("rst_mid", 3'b000, 0, 0, 0, 10, 0);
    reset_n              = 1'b1;
    u_if.i_current_total = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("post_rst%0d", i), 3'b000, 0, 0, 0,
              32'(9 - i), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/change_return_timer.md
Name: change_return_timer

Overview:
- Parametrised successor of the vending machine's timeout/coin-return block.
- Tracks a refreshable inactivity timer. On timeout or an explicit return request, it dispenses change sequentially.
- Change is greedy, one coin per cycle, largest denomination first, and may repeat the same denomination.
- Sits between the coin/item datapath, which owns current_total, and the coin-return actuator.

Parameters:
NUM_COINS, 3, number of coin denominations
NUM_ITEMS, 4, number of item-dispense lines
TOTAL_BITS, 31, width of the balance
VALUE_BITS, 16, width of one coin value (VALUE_BITS <= TOTAL_BITS)
TIMER_BITS, 32, width of the inactivity counter
WAIT_TIME, 10, timer reload value in cycles (>= 1)
WARN_TIME, 3, warning threshold in cycles (used only with the optional feature; < WAIT_TIME)

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset_n  in  1  reset, synchronous, active-low
i_input_coin  in  NUM_COINS  coin-insert strobes; any nonzero value counts as activity
i_output_item  in  NUM_ITEMS  item-dispense strobes; any nonzero value counts as activity
i_trigger_return  in  1  user return request (level, sampled each edge)
i_current_total  in  TOTAL_BITS  current balance held by the datapath
i_coin_value  in  NUM_COINS*VALUE_BITS  flattened coin values; coin k at [k*VALUE_BITS +: VALUE_BITS]; strictly ascending in k; value 0 = denomination disabled
o_return_coin  out  NUM_COINS  one-hot coin-eject pulse, or all zero (registered)
o_return_busy  out  1  high while in RETURN
o_return_done  out  1  one-cycle pulse at the end of a return sequence
o_residual  out  TOTAL_BITS  unreturnable remainder; valid while o_return_done is high, holds until the next done
o_wait_time  out  TIMER_BITS  current timer value
o_warn  out  1  timeout warning (optional feature)

Behaviour:
- Reset (reset_n low at an edge):
  - state IDLE, o_wait_time = WAIT_TIME.
  - o_return_coin, o_return_busy, o_return_done, o_warn all 0; o_residual 0; internal remaining 0.
  - Reset applied mid-RETURN aborts the sequence: no further coins, no done pulse.
- IDLE, evaluated per edge in this priority order:
  1. Activity (i_input_coin != 0 or i_output_item != 0): o_wait_time <= WAIT_TIME. Activity beats a simultaneous trigger.
  2. i_trigger_return: enter RETURN.
  3. o_wait_time == 0 and i_current_total != 0: enter RETURN (timeout return).
  4. o_wait_time > 0: decrement by 1. At 0 with a zero balance, the timer holds at 0 and no return starts.
- Entering RETURN: remaining <= i_current_total, o_return_busy <= 1, o_return_coin <= 0.
- RETURN, each edge:
  - Find the highest k with value_k != 0 and value_k <= remaining (values zero-extended to TOTAL_BITS).
  - If found: o_return_coin <= (1 << k), remaining <= remaining - value_k.
  - Else: o_return_coin <= 0, o_return_done <= 1, o_residual <= remaining, o_return_busy <= 0, o_wait_time <= WAIT_TIME, state <= IDLE.
- Latency: a sequence returning n coins emits pulses on edges S+1..S+n and done on edge S+n+1, where S is the start edge.
- Trigger with zero balance: RETURN for one edge, then done with residual 0 and no coins.
- Inputs ignored during RETURN: activity and trigger; the timer does not count.
- Pulse widths: o_return_done is exactly one cycle. o_return_coin is never multi-hot.
- i_current_total is sampled only at RETURN entry. Changes during RETURN are the datapath's concern.

Optional Feature:
- Macro: CHANGE_RETURN_WARN_EN.
- Defined: in IDLE, o_warn is registered high when the next o_wait_time is in 1..WARN_TIME and i_current_total != 0. It is low otherwise, including in RETURN and after an activity reload.
- Undefined: o_warn is a constant 0 and no comparator logic is built.

Test Plan:
- Defaults, values {10,50,100}, total 160, trigger at edge S -> o_return_coin 100,010,001 on S+1..S+3; done at S+4, residual 0; o_wait_time = 10 after done.
- Total 250, no activity -> timer counts 10..0; return of 100,100,50; done with residual 0.
- Values {10,50,100}, total 75, trigger -> coins 50 then 10; done, residual 5.
- Coin strobe at every 9th cycle, total 30 -> timer never reaches 0; no return; o_wait_time reloads to 10 each time.
- reset_n low on the cycle after the first coin pulse of a 250 return -> all outputs 0 and o_wait_time 10 next cycle; no done pulse.
- With CHANGE_RETURN_WARN_EN, total 20, idle -> o_warn high while o_wait_time is 3..1; drops on a coin strobe. With the macro undefined, o_warn is constant 0.
